pdm_mod: RTL and testbench



---
 rtl/pdm_pkg.sv | 41 ++++
 rtl/pdm_sdm2.sv | 54 +++++
 rtl/pdm_mod.sv | 59 +++++
 tb/tb_pdm_mod.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and arithmetic helpers for the PCM-to-PDM modulator.
// All helpers work on 64-bit signed values so any WIDTH up to ~56 fits.
package pdm_pkg;

   localparam int WIDTH_DEF  = 24;
   localparam int OSR_DEF    = 64;
   localparam int INT1_GUARD = 2;
   localparam int INT2_GUARD = 4;

   function automatic int int1_w(input int width);
      return width + INT1_GUARD;
   endfunction

   function automatic int int2_w(input int width);
      return width + INT2_GUARD;
   endfunction

   // Full-scale magnitude 2^(width-1)
   function automatic logic signed [63:0] fs_of(input int width);
      return 64'sd1 <<< (width - 1);
   endfunction

   // Input limit 3*2^(width-3) = 0.75 FS, inside the stable region of the loop
   function automatic logic signed [63:0] lim_of(input int width);
      return 64'sd3 <<< (width - 3);
   endfunction

   function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                              input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      return value;
   endfunction

endpackage

// File: rtl/pdm_sdm2.sv
// Second-order sigma-delta core: clamps the input, runs two saturating
// integrators with 1-bit feedback and registers the output bit.
module pdm_sdm2
   import pdm_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic signed [WIDTH-1:0] x,
   output logic                    dout
);

   localparam int I1W = int1_w(WIDTH);
   localparam int I2W = int2_w(WIDTH);
   localparam logic signed [63:0] FS  = fs_of(WIDTH);
   localparam logic signed [63:0] LIM = lim_of(WIDTH);

   logic signed [I1W-1:0] int1_reg, int1_next;
   logic signed [I2W-1:0] int2_reg, int2_next;
   logic                  dout_reg, dout_next;
   logic signed [63:0]    x_ext, x_clamped, fb, int1_ext, int2_ext;

   always_comb begin
      x_ext    = {{(64-WIDTH){x[WIDTH-1]}}, x};
      int1_ext = {{(64-I1W){int1_reg[I1W-1]}}, int1_reg};
      int2_ext = {{(64-I2W){int2_reg[I2W-1]}}, int2_reg};
      x_clamped = x_ext;
      if (x_ext > LIM)
         x_clamped = LIM;
      else if (x_ext < -LIM)
         x_clamped = -LIM;
      fb = dout_reg ? FS : -FS;
      // Second integrator consumes the pre-update int1
      int1_next = I1W'(sat(int1_ext + x_clamped - fb, I1W));
      int2_next = I2W'(sat(int2_ext + int1_ext - fb, I2W));
      dout_next = ~int2_next[I2W-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int1_reg <= '0;
         int2_reg <= '0;
         dout_reg <= 1'b0;
      end else begin
         int1_reg <= int1_next;
         int2_reg <= int2_next;
         dout_reg <= dout_next;
      end
   end

   assign dout = dout_reg;

endmodule

// File: rtl/pdm_mod.sv
// PCM-to-PDM modulator: one-entry input buffer feeding a sample held for
// OSR clocks, driving the second-order sigma-delta core.
module pdm_mod
   import pdm_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OSR   = OSR_DEF
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic signed [WIDTH-1:0] din,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic                    dout,
   output logic                    underrun
);

   localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

   logic [PW-1:0]          phase_reg;
   logic signed [WIDTH-1:0] cur_reg, nxt_reg;
   logic                   nxt_v_reg;
   logic                   boundary, accept;

   assign boundary  = (phase_reg == PW'(OSR - 1));
   // The boundary frees the buffer in the same cycle, so a refill is allowed
   assign din_ready = !nxt_v_reg || boundary;
   assign accept    = din_valid && din_ready;
   assign underrun  = boundary && !nxt_v_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_reg <= '0;
         cur_reg   <= '0;
         nxt_reg   <= '0;
         nxt_v_reg <= 1'b0;
      end else begin
         phase_reg <= boundary ? '0 : phase_reg + PW'(1);
         if (boundary && nxt_v_reg)
            cur_reg <= nxt_reg;
         if (accept) begin
            nxt_reg   <= din;
            nxt_v_reg <= 1'b1;
         end else if (boundary) begin
            nxt_v_reg <= 1'b0;
         end
      end
   end

   pdm_sdm2 #(
      .WIDTH (WIDTH)
   ) u_sdm (
      .clk     (clk),
      .reset_n (reset_n),
      .x       (cur_reg),
      .dout    (dout)
   );

endmodule

// File: tb/tb_pdm_mod.sv
// Self-checking bench for pdm_mod: scoreboard of accepted samples drives
// handshake/underrun expectations; pulse density checked against x/FS.
module tb_pdm_mod;

   localparam int  WIDTH = 24;
   localparam int  OSR   = 64;
   localparam real FSR   = 8388608.0;
   localparam real LIMR  = 6291456.0;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic signed [WIDTH-1:0] din = '0;
   logic                    din_valid = 1'b0;
   logic                    din_ready, dout, underrun;

   int tests = 0;
   int fails = 0;

   // Scoreboard/model state, owned by the monitor
   logic signed [WIDTH-1:0] nxtq[$];
   logic signed [WIDTH-1:0] cur_m = '0;
   int  phase_m = 0;
   bit  acc_en = 1'b0;
   int  acc_n = 0, acc_ones = 0, acc_under = 0;
   real acc_x = 0.0;

   pdm_mod #(.WIDTH(WIDTH), .OSR(OSR)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (dout),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp_lo, input int exp_hi);
      tests++;
      if (act < exp_lo || act > exp_hi) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, exp_lo, exp_hi);
      end else begin
         $display("[TB] %s: %0d (expected %0d..%0d)", name, act, exp_lo, exp_hi);
      end
   endtask

   function automatic real clampx(input logic signed [WIDTH-1:0] v);
      real r;
      r = real'(v);
      if (r > LIMR) return LIMR;
      if (r < -LIMR) return -LIMR;
      return r;
   endfunction

   // Monitor: spec-level model of the phase counter and one-deep buffer
   always @(negedge clk) begin
      bit boundary, exp_ready, exp_under;
      if (!reset_n) begin
         phase_m = 0;
         nxtq.delete();
         cur_m = '0;
      end else begin
         boundary  = (phase_m == OSR - 1);
         exp_ready = (nxtq.size() == 0) || boundary;
         exp_under = boundary && (nxtq.size() == 0);
         chk_bit("din_ready", din_ready, exp_ready);
         chk_bit("underrun", underrun, exp_under);
         if (boundary && nxtq.size() > 0)
            cur_m = nxtq.pop_front();
         if (din_valid && exp_ready)
            nxtq.push_back(din);
         phase_m = boundary ? 0 : phase_m + 1;
      end
      if (acc_en) begin
         acc_n++;
         acc_ones  += int'(dout);
         acc_under += int'(underrun);
         acc_x     += clampx(cur_m) / FSR;
      end else begin
         acc_n = 0; acc_ones = 0; acc_under = 0; acc_x = 0.0;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n   = 1'b0;
      din_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // Count ones over n clocks; expected = (n + sum x/FS)/2 within tol
   task automatic window(input string name, input int n, input real tol, input int exp_under);
      real expd;
      acc_en = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      expd = (real'(acc_n) + acc_x) / 2.0;
      chk_int({name, " ones"}, acc_ones, $rtoi(expd - tol + 0.999), $rtoi(expd + tol));
      if (exp_under >= 0)
         chk_int({name, " underruns"}, acc_under, exp_under, exp_under);
      acc_en = 1'b0;
   endtask

   task automatic send(input logic signed [WIDTH-1:0] v, output int waited);
      bit got;
      din = v; din_valid = 1'b1; waited = 0; got = 0;
      for (int k = 0; k < 4 * OSR && !got; k++) begin
         @(negedge clk);
         if (din_ready) got = 1;
         @(posedge clk); #1;
         if (!got) waited++;
      end
      if (!got) begin
         tests++; fails++;
         $display("[TB] FAIL send timeout: got no din_ready expected din_ready=1");
      end
   endtask

   initial begin
      int w;
      logic signed [WIDTH-1:0] s;

      // Reset state with clock idle
      #2;
      chk_bit("reset dout", dout, 1'b0);
      chk_bit("reset underrun", underrun, 1'b0);
      chk_bit("reset din_ready", din_ready, 1'b1);

      // Zero input, accepted once: density 1/2, underrun each period
      do_reset();
      din = '0; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      repeat (OSR - 1) @(posedge clk);
      #1;
      window("zero", 4096, 8.0, 64);

      // Positive clamp, refilled every boundary
      do_reset();
      din = 24'sh7FFFFF; din_valid = 1'b1;
      repeat (2 * OSR) @(posedge clk);
      #1;
      window("pos clamp", 4096, 8.0, 0);
      chk_int("pos clamp exp", $rtoi((4096.0 * 1.75) / 2.0), 3584, 3584);

      // Negative full scale, refilled every boundary
      do_reset();
      din = 24'sh800000; din_valid = 1'b1;
      repeat (2 * OSR) @(posedge clk);
      #1;
      window("neg clamp", 4096, 8.0, 0);

      // Asynchronous reset mid-stream, buffer full and dout toggling
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk_bit("midreset dout", dout, 1'b0);
      chk_bit("midreset underrun", underrun, 1'b0);
      chk_bit("midreset din_ready", din_ready, 1'b1);
      din_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2 * OSR) @(posedge clk);

      // Handshake: A at phase 0, B waits until the boundary at phase 63
      do_reset();
      send(24'sh100000, w);
      chk_int("A wait", w, 0, 0);
      send(-24'sh080000, w);
      chk_int("B wait", w, OSR - 2, OSR - 2);
      din_valid = 1'b0;
      repeat (3 * OSR) @(posedge clk);

      // Random valid/data traffic against the scoreboard
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         din_valid = ($urandom_range(0, 3) == 0);
         din = WIDTH'($urandom);
         @(posedge clk); #1;
      end
      din_valid = 1'b0;

      // Loopback: sine at 0.5 FS, averaged density tracks input within 1% FS
      do_reset();
      fork
         begin
            for (int i = 0; i < 84; i++) begin
               s = WIDTH'($rtoi(0.5 * FSR * $sin(2.0 * 3.14159265358979 * real'(i) / 48.0)));
               send(s, w);
            end
            din_valid = 1'b0;
         end
         begin
            repeat (3 * OSR) @(posedge clk);
            #1;
            window("sine w0", 2048, 0.005 * 2048.0, 0);
            window("sine w1", 2048, 0.005 * 2048.0, 0);
         end
      join

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
